// File: rtl/output_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : output_port_arbiter_pkg
//  Description : Shared constants and state encoding for the output port
//                arbiter and its round-robin picker.
//  Revision    : 1.0 - initial release
// ============================================================================
package output_port_arbiter_pkg;

    // Default flit width in bits.
    localparam int FLIT_SIZE  = 16;

    // Tail flag position within a [1:FLIT_W] flit vector (the MSB).
    localparam int TAIL_BIT   = 1;

    // Width of a port index; supports up to 8 input ports.
    localparam int PORT_IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/output_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : output_port_arbiter_if
//  Description : Bundle of input-port request/flit/ack signals and the
//                downstream output-stage handshake of the output arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface output_port_arbiter_if
    import output_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 5,
    parameter int FLIT_W    = FLIT_SIZE,
    parameter int CNT_W     = 16
);

    logic [NUM_PORTS-1:0]        port_isNew;
    logic [NUM_PORTS*FLIT_W-1:0] port_flit;
    logic [NUM_PORTS-1:0]        port_ack;
    logic                        out_valid;
    logic                        out_ready;
    logic [1:FLIT_W]             out_flit;
    logic [PORT_IDX_W-1:0]       out_src;
    logic [CNT_W-1:0]            flit_count;

    // Environment side: input ports and downstream consumer.
    modport master (
        output port_isNew, port_flit, out_ready,
        input  port_ack, out_valid, out_flit, out_src, flit_count
    );

    // Arbiter side.
    modport slave (
        input  port_isNew, port_flit, out_ready,
        output port_ack, out_valid, out_flit, out_src, flit_count
    );

endinterface
`default_nettype wire

// File: rtl/output_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin search. Returns the first set
//                request at or after the start index, wrapping, as a one-hot
//                grant, a binary index and a found flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import output_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 5
) (
    input  logic [NUM_PORTS-1:0]  req,
    input  logic [PORT_IDX_W-1:0] start,
    output logic [NUM_PORTS-1:0]  grant,
    output logic [PORT_IDX_W-1:0] idx,
    output logic                  any_req
);

    // Walk the ports starting at the given index; the first hit wins.
    always_comb begin
        int j;
        j       = 0;
        grant   = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            j = int'(start) + k;
            if (j >= NUM_PORTS) begin
                j = j - NUM_PORTS;
            end
            if (!any_req && req[j]) begin
                any_req  = 1'b1;
                idx      = PORT_IDX_W'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/output_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : output_port_arbiter
//  Description : Round-robin arbiter for one output port with packet locking
//                (wormhole style), a single output register stage and a
//                saturating forwarded-flit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_port_arbiter
    import output_port_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 5,
    parameter int FLIT_W    = FLIT_SIZE,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output_port_arbiter_if.slave bus
);

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    logic [PORT_IDX_W-1:0]   r_last_grant;
    logic [PORT_IDX_W-1:0]   r_owner;
    logic [PORT_IDX_W-1:0]   w_start;
    logic [PORT_IDX_W-1:0]   w_pick_idx;
    logic [NUM_PORTS-1:0]    w_owner_mask;
    logic [NUM_PORTS-1:0]    w_req;
    logic [NUM_PORTS-1:0]    w_pick_oh;
    logic                    w_pick_any;
    logic                    w_free;
    logic                    w_grant;
    logic                    w_tail;
    logic [FLIT_W-1:0]       w_flits [NUM_PORTS];
    logic [FLIT_W-1:0]       w_sel_flit;

    logic                    r_out_valid;
    logic [1:FLIT_W]         r_out_flit;
    logic [PORT_IDX_W-1:0]   r_out_src;
    logic [CNT_W-1:0]        r_flit_count;

    // Port 0 occupies the most-significant slice of the concatenated bus.
    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
            assign w_flits[g] = bus.port_flit[(NUM_PORTS-1-g)*FLIT_W +: FLIT_W];
        end
    endgenerate

    // While a packet is in flight only its owner may compete.
    assign w_owner_mask = NUM_PORTS'(1) << r_owner;
    assign w_req        = (r_state == LOCKED) ? (bus.port_isNew & w_owner_mask)
                                              : bus.port_isNew;
    assign w_start      = (r_last_grant == PORT_IDX_W'(NUM_PORTS-1))
                          ? '0 : r_last_grant + PORT_IDX_W'(1);

    rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_pick (
        .req     (w_req),
        .start   (w_start),
        .grant   (w_pick_oh),
        .idx     (w_pick_idx),
        .any_req (w_pick_any)
    );

    // The output register can take a new flit if empty or draining this cycle.
    // Grants are suppressed while reset is held so no ack leaks out.
    assign w_free     = !r_out_valid || bus.out_ready;
    assign w_grant    = w_free && w_pick_any && rst_n;
    assign w_sel_flit = w_flits[w_pick_idx];
    assign w_tail     = w_sel_flit[FLIT_W-TAIL_BIT];

    assign bus.port_ack   = w_grant ? w_pick_oh : '0;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_flit   = r_out_flit;
    assign bus.out_src    = r_out_src;
    assign bus.flit_count = r_flit_count;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lock on a non-tail grant from IDLE; unlock when the owner's tail is granted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant && !w_tail) w_state_nxt = LOCKED;
            LOCKED:  if (w_grant &&  w_tail) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Round-robin pointer and lock owner; reset pointer gives port 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= PORT_IDX_W'(NUM_PORTS-1);
            r_owner      <= '0;
        end else if (w_grant) begin
            r_last_grant <= w_pick_idx;
            if (r_state == IDLE) begin
                r_owner <= w_pick_idx;
            end
        end
    end

    // Output stage: load on grant, empty on transfer without refill, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
            r_out_src   <= '0;
        end else if (w_grant) begin
            r_out_valid <= 1'b1;
            r_out_flit  <= w_sel_flit;
            r_out_src   <= w_pick_idx;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Count flits taken by downstream, sticking at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flit_count <= '0;
        end else if (r_out_valid && bus.out_ready && (r_flit_count != {CNT_W{1'b1}})) begin
            r_flit_count <= r_flit_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_port_arbiter
//  Description : Self-checking bench for output_port_arbiter. Input ports are
//                modelled as flit queues; a behavioural model of the
//                arbitration rules predicts acks and the output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_output_port_arbiter;
    import output_port_arbiter_pkg::*;

    localparam int NP   = 5;
    localparam int FW   = FLIT_SIZE;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    output_port_arbiter_if #(.NUM_PORTS(NP), .FLIT_W(FW), .CNT_W(CW)) bus ();

    output_port_arbiter #(
        .NUM_PORTS (NP),
        .FLIT_W    (FW),
        .CNT_W     (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [FW-1:0] pq [NP][$];
    bit          gate [NP];
    int          dut_gnt [$];

    // Reference model of the arbiter's observable state
    bit            m_valid;
    logic [FW-1:0] m_flit;
    int            m_src;
    int            m_cnt;
    int            m_last;
    bit            m_locked;
    int            m_owner;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int gq(input int k);
        return (k < dut_gnt.size()) ? dut_gnt[k] : -1;
    endfunction

    task automatic push_pkt(input int port, input int len);
        logic [FW-1:0] f;
        for (int k = 0; k < len; k++) begin
            f = FW'($urandom);
            f[FW-1] = (k == len - 1);
            pq[port].push_back(f);
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_flit   = '0;
        m_src    = 0;
        m_cnt    = 0;
        m_last   = NP - 1;
        m_locked = 1'b0;
        m_owner  = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            bit nw;
            nw = (pq[i].size() > 0) && gate[i];
            bus.port_isNew[i] = nw;
            bus.port_flit[(NP-1-i)*FW +: FW] = nw ? pq[i][0] : FW'($urandom);
        end
    endtask

    // Which port should win this cycle, or -1 for none.
    function automatic int model_pick();
        if (m_valid && !bus.out_ready) return -1;
        for (int k = 1; k <= NP; k++) begin
            int p;
            p = (m_last + k) % NP;
            if (bus.port_isNew[p] && (!m_locked || p == m_owner)) return p;
        end
        return -1;
    endfunction

    // One clock cycle: entered and left at a falling edge.
    task automatic step();
        int            g;
        logic [FW-1:0] gf;
        logic [NP-1:0] eack;
        bit            rdy;
        drive();
        #1;
        g    = model_pick();
        eack = '0;
        gf   = '0;
        if (g >= 0) eack[g] = 1'b1;
        chk("port_ack", 32'(bus.port_ack), 32'(eack));
        for (int i = 0; i < NP; i++) begin
            if (bus.port_ack[i]) dut_gnt.push_back(i);
        end
        rdy = bus.out_ready;
        if (g >= 0) gf = pq[g][0];
        @(posedge clk);
        if (m_valid && rdy && m_cnt < CMAX) m_cnt++;
        if (g >= 0) begin
            m_valid = 1'b1;
            m_flit  = gf;
            m_src   = g;
            m_last  = g;
            if (!m_locked) begin
                if (!gf[FW-1]) begin
                    m_locked = 1'b1;
                    m_owner  = g;
                end
            end else if (gf[FW-1]) begin
                m_locked = 1'b0;
            end
            void'(pq[g].pop_front());
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
        chk("out_flit", 32'(bus.out_flit), 32'(m_flit));
        if (m_valid) chk("out_src", 32'(bus.out_src), m_src);
        chk("flit_count", 32'(bus.flit_count), m_cnt);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.port_isNew = '0;
        bus.port_flit  = '0;
        bus.out_ready  = 1'b1;
        for (int i = 0; i < NP; i++) gate[i] = 1'b1;
        model_reset();

        // Reset state, with a request pending during reset
        push_pkt(1, 1);
        drive();
        #2;
        chk("rst_ack",   32'(bus.port_ack), 0);
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_flit",  32'(bus.out_flit), 0);
        chk("rst_src",   32'(bus.out_src), 0);
        chk("rst_cnt",   32'(bus.flit_count), 0);
        @(negedge clk);
        @(negedge clk);
        pq[1].delete();
        rst_n = 1'b1;

        // Two single-flit requesters: 2 then 4 on consecutive cycles
        dut_gnt.delete();
        push_pkt(2, 1);
        push_pkt(4, 1);
        repeat (2) step();
        chk("a_n",  dut_gnt.size(), 2);
        chk("a_g0", gq(0), 2);
        chk("a_g1", gq(1), 4);
        repeat (2) step();

        // Three-flit packet on port 1 locks out port 3
        dut_gnt.delete();
        push_pkt(1, 3);
        repeat (3) push_pkt(3, 1);
        repeat (4) step();
        chk("b_n",  dut_gnt.size(), 4);
        chk("b_g0", gq(0), 1);
        chk("b_g1", gq(1), 1);
        chk("b_g2", gq(2), 1);
        chk("b_g3", gq(3), 3);
        repeat (3) step();

        // Downstream stall for 4 cycles: no acks, output held
        push_pkt(0, 1);
        push_pkt(0, 1);
        step();
        bus.out_ready = 1'b0;
        dut_gnt.delete();
        repeat (4) step();
        chk("c_noack", dut_gnt.size(), 0);
        bus.out_ready = 1'b1;
        repeat (3) step();

        // All ports requesting: grants 0..4,0 back to back
        do_reset();
        for (int p = 0; p < NP; p++) begin
            push_pkt(p, 1);
            push_pkt(p, 1);
        end
        dut_gnt.delete();
        repeat (6) step();
        chk("d_n",  dut_gnt.size(), 6);
        chk("d_g0", gq(0), 0);
        chk("d_g1", gq(1), 1);
        chk("d_g2", gq(2), 2);
        chk("d_g3", gq(3), 3);
        chk("d_g4", gq(4), 4);
        chk("d_g5", gq(5), 0);
        chk("d_cnt", 32'(bus.flit_count), 5);
        repeat (6) step();

        // Asynchronous reset while locked with a held flit
        push_pkt(2, 3);
        step();
        bus.out_ready = 1'b0;
        step();
        push_pkt(3, 1);
        push_pkt(1, 1);
        drive();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("e_valid", 32'(bus.out_valid), 0);
        chk("e_ack",   32'(bus.port_ack), 0);
        pq[2].delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        dut_gnt.delete();
        step();
        chk("e_first", gq(0), 1);
        repeat (3) step();

        // Counter saturation
        do_reset();
        for (int k = 0; k < 22; k++) push_pkt(k % NP, 1);
        repeat (26) step();
        chk("f_sat", 32'(bus.flit_count), CMAX);

        // Randomized traffic
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                int p;
                p = $urandom_range(0, NP - 1);
                if (pq[p].size() < 6) push_pkt(p, $urandom_range(1, 4));
            end
            for (int i = 0; i < NP; i++) gate[i] = ($urandom_range(0, 9) < 8);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if (it == 300) do_reset();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
